// File: rtl/clcd_init_sequencer.sv
// clcd_init_sequencer: power-up wait then HD44780 init command list over valid/busy handshake
module clcd_init_sequencer #(
    parameter int POWERUP_CYC    = 4_000_000,
    parameter int CMD_GAP_CYC    = 5_000,
    parameter int CLEAR_WAIT_CYC = 200_000,
    parameter int TIMEOUT_CYC    = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       init_start,
    input  logic       busy_CLCD,
    output logic [7:0] data_CLCD,
    output logic       RS_CLCD,
    output logic       RW_CLCD,
    output logic       valid_CLCD,
    output logic       init_done,
    output logic       init_error,
    output logic [2:0] cmd_index
);
    localparam int MAX_A = (POWERUP_CYC > CMD_GAP_CYC) ? POWERUP_CYC : CMD_GAP_CYC;
    localparam int MAX_B = (CLEAR_WAIT_CYC > TIMEOUT_CYC) ? CLEAR_WAIT_CYC : TIMEOUT_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] PWR_END = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] GAP_END = CW'(CMD_GAP_CYC - 1);
    localparam logic [CW-1:0] CLR_END = CW'(CLEAR_WAIT_CYC - 1);
    localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] ROM [8] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h01, 8'h06, 8'h00, 8'h00};

    typedef enum logic [2:0] {S_POWERUP, S_ISSUE, S_ACCEPT, S_SENDING, S_GAP, S_DONE, S_ERROR} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy_d;
    logic [2:0]      r_idx;
    logic            w_pedge;
    logic            w_nedge;
    logic            w_timeout;
    logic [CW-1:0]   w_gap_end;

    assign w_pedge   = busy_CLCD & ~r_busy_d;
    assign w_nedge   = ~busy_CLCD & r_busy_d;
    assign w_timeout = (r_cnt == TO_END);
    // clear-display needs a much longer settle than the other commands
    assign w_gap_end = (r_idx == 3'd4) ? CLR_END : GAP_END;
    assign RS_CLCD   = 1'b0;
    assign RW_CLCD   = 1'b0;
    assign cmd_index = r_idx;

    // sequencer FSM: shared counter serves power-up wait, handshake timeout and settle gap
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state    <= S_POWERUP;
            r_cnt      <= '0;
            r_busy_d   <= 1'b0;
            r_idx      <= '0;
            data_CLCD  <= '0;
            valid_CLCD <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            r_busy_d <= busy_CLCD;
            r_cnt    <= r_cnt + 1'b1;
            case (r_state)
                S_POWERUP: if (r_cnt == PWR_END) begin
                    r_state <= S_ISSUE;
                    r_idx   <= '0;
                    r_cnt   <= '0;
                end
                S_ISSUE: begin
                    data_CLCD  <= ROM[r_idx];
                    valid_CLCD <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_ACCEPT;
                end
                S_ACCEPT: if (w_pedge) begin
                    valid_CLCD <= 1'b0;
                    r_state    <= S_SENDING;
                end else if (w_timeout) begin
                    valid_CLCD <= 1'b0;
                    init_error <= 1'b1;
                    r_state    <= S_ERROR;
                end
                S_SENDING: if (w_nedge) begin
                    r_cnt   <= '0;
                    r_state <= S_GAP;
                end else if (w_timeout) begin
                    init_error <= 1'b1;
                    r_state    <= S_ERROR;
                end
                S_GAP: if (r_cnt == w_gap_end) begin
                    r_cnt <= '0;
                    if (r_idx == 3'd5) begin
                        init_done <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    valid_CLCD <= 1'b0;
                    if (init_start) begin
                        init_done <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ERROR: begin
                    valid_CLCD <= 1'b0;
                    if (init_start) begin
                        init_error <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                default: r_state <= S_POWERUP;
            endcase
        end
    end
endmodule

// File: tb/tb_clcd_init_sequencer.sv
// tb_clcd_init_sequencer: randomized handshake peripheral against an event-time reference model
module tb_clcd_init_sequencer;
    localparam int PW = 20, GP = 4, CL = 10, TO = 50;
    localparam logic [7:0] CMDS [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h01, 8'h06};

    logic       clk = 1'b0, reset_p = 1'b1, init_start = 1'b0, busy_CLCD = 1'b0;
    logic [7:0] data_CLCD;
    logic       RS_CLCD, RW_CLCD, valid_CLCD, init_done, init_error;
    logic [2:0] cmd_index;
    int         cyc = 0, n_cmp = 0, n_err = 0, t0 = 0;

    clcd_init_sequencer #(.POWERUP_CYC(PW), .CMD_GAP_CYC(GP), .CLEAR_WAIT_CYC(CL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_p(reset_p), .init_start(init_start), .busy_CLCD(busy_CLCD),
        .data_CLCD(data_CLCD), .RS_CLCD(RS_CLCD), .RW_CLCD(RW_CLCD), .valid_CLCD(valid_CLCD),
        .init_done(init_done), .init_error(init_error), .cmd_index(cmd_index)
    );

    always #5 clk = ~clk;

    // one clock: cycle number counts posedges, observation happens at the following negedge
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        init_start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int idx, input int exp_v);
        int t = 0;
        while (valid_CLCD !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        chk($sformatf("valid_rise_cyc[%0d]", idx), cyc, exp_v);
        chk($sformatf("data[%0d]", idx), data_CLCD, CMDS[idx]);
        chk($sformatf("rs_rw[%0d]", idx), {RS_CLCD, RW_CLCD}, 0);
        chk($sformatf("cmd_index[%0d]", idx), cmd_index, idx);
    endtask

    // Drives one pass of the command list. Expected times follow the handshake rules:
    // next valid = (edge busy first seen low) + gap + 1, done = that edge + gap.
    task automatic run_seq(input int first_v, input int abort_idx, input int pulse_idx,
                           input int h1_idx, input int stall_idx);
        int exp_v = first_v, d, h, fs = 0, v, t;
        for (int i = 0; i < 6; i++) begin
            wait_valid(i, exp_v);
            v = cyc;
            if (i == stall_idx) begin
                t = 0;
                while (init_error !== 1'b1 && t < 200) begin
                    tick();
                    t++;
                end
                chk("timeout_cyc", cyc, v + TO);
                chk("timeout_valid", valid_CLCD, 0);
                repeat (10) tick();
                chk("error_held", {init_error, init_done, valid_CLCD}, 3'b100);
                return;
            end
            d = $urandom_range(1, 4);
            h = (i == h1_idx) ? 1 : $urandom_range(1, 10);
            repeat (d) tick();
            busy_CLCD = 1'b1;
            tick();
            chk($sformatf("valid_drop[%0d]", i), valid_CLCD, 0);
            if (i == abort_idx) begin
                reset_p = 1'b1;
                tick();
                chk("reset_mid_outputs", {data_CLCD, RS_CLCD, RW_CLCD, valid_CLCD, init_done, init_error, cmd_index}, 0);
                reset_p   = 1'b0;
                busy_CLCD = 1'b0;
                return;
            end
            repeat (h - 1) tick();
            chk($sformatf("data_held[%0d]", i), data_CLCD, CMDS[i]);
            busy_CLCD = 1'b0;
            if (i == pulse_idx) init_start = 1'b1;
            fs = cyc + 1;
            exp_v = fs + ((i == 4) ? CL : GP) + 1;
        end
        t = 0;
        while (init_done !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        chk("done_cyc", cyc, fs + GP);
        chk("done_flags", {init_done, init_error, valid_CLCD, cmd_index}, {3'b100, 3'd5});
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outputs", {data_CLCD, RS_CLCD, RW_CLCD, valid_CLCD, init_done, init_error, cmd_index}, 0);
        reset_p    = 1'b0;
        init_start = 1'b1;
        t0 = cyc;
        run_seq(t0 + PW + 1, -1, 1, -1, -1);
        init_start = 1'b1;
        t0 = cyc;
        tick();
        chk("restart_done_clr", init_done, 0);
        run_seq(t0 + 2, -1, 4, 3, -1);
        init_start = 1'b1;
        t0 = cyc;
        tick();
        run_seq(t0 + 2, -1, -1, -1, 2);
        init_start = 1'b1;
        t0 = cyc;
        tick();
        chk("error_clr", init_error, 0);
        run_seq(t0 + 2, -1, -1, 0, -1);
        init_start = 1'b1;
        t0 = cyc;
        tick();
        run_seq(t0 + 2, 3, -1, -1, -1);
        t0 = cyc;
        run_seq(t0 + PW + 1, -1, -1, 5, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
